// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_pkg: shared constants for the load/store unit.
//   - RV32i funct3 codes for loads and stores
//   - controller state encoding
//   - default memory acknowledge timeout
//   - access_bad(): misalignment / illegal funct3 detection
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int TIMEOUT_DEFAULT = 16;

  // True when the access must be rejected without touching memory.
  // Halfword codes share funct3[1:0]==01 and word codes 10, so the
  // alignment test is independent of the signed/unsigned bit.
  function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal;
    logic misal;
    if (we) illegal = (f3 > F3_W);
    else    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misal = ((f3[1:0] == 2'b01) && off[0]) ||
            ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misal;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: core request/response and data-memory bus bundle.
//   master : the environment (core execute stage + data memory model)
//   slave  : the load/store unit itself
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
  // core side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_misalign;
  logic              rsp_timeout;
  // memory side
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_timeout,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_timeout,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: purely combinational lane logic.
//   funct3, offset  : access size/sign and byte offset within the word
//   wdata_in        : store data (rs2)      -> wdata_out, lane-replicated
//   rdata_in        : raw memory word       -> rdata_out, extracted/extended
//   be              : byte enables for the access (same for loads and stores)
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);
  logic [31:0] shifted;

  always_comb begin
    // bring the addressed byte/half down to bit 0
    shifted   = rdata_in >> {offset, 3'b000};
    be        = 4'b1111;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << offset;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = funct3[2] ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << offset;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = funct3[2] ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the execute stage and data memory.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : lsu_mem_ctrl_if.slave carrying the core request/response
//              channel and the data-memory request/ack channel
// One access in flight: IDLE -> REQ -> (WAIT) -> RESP -> IDLE, or
// IDLE -> ERR -> IDLE for misaligned/illegal requests.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  lsu_mem_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_reg, state_next;
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [1:0]        off_reg;
  logic [3:0]        be_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              timeout_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  // One aligner serves both paths: in IDLE it formats the incoming store,
  // afterwards it extracts load data using the captured request fields.
  assign al_f3  = (state_reg == S_IDLE) ? bus.req_funct3     : f3_reg;
  assign al_off = (state_reg == S_IDLE) ? bus.req_addr[1:0]  : off_reg;

  lsu_align u_align (
    .funct3    (al_f3),
    .offset    (al_off),
    .wdata_in  (bus.req_wdata),
    .rdata_in  (bus.mem_rdata),
    .be        (al_be),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (bus.req_valid)
                state_next = access_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0])
                             ? S_ERR : S_REQ;
      S_REQ:  if (bus.mem_gnt) state_next = bus.mem_rvalid ? S_RESP : S_WAIT;
      // rvalid on the last counted cycle still completes normally
      S_WAIT: if (bus.mem_rvalid || (cnt_reg == CNT_LAST)) state_next = S_RESP;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      we_reg      <= 1'b0;
      f3_reg      <= 3'b0;
      off_reg     <= 2'b0;
      be_reg      <= 4'b0;
      addr_reg    <= '0;
      wdata_reg   <= 32'b0;
      rdata_reg   <= 32'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (bus.req_valid) begin
          we_reg      <= bus.req_we;
          f3_reg      <= bus.req_funct3;
          off_reg     <= bus.req_addr[1:0];
          be_reg      <= al_be;
          addr_reg    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          wdata_reg   <= al_wdata;
          rdata_reg   <= 32'b0;
          timeout_reg <= 1'b0;
          cnt_reg     <= '0;
        end
        S_REQ: if (bus.mem_gnt && bus.mem_rvalid)
          rdata_reg <= we_reg ? 32'b0 : al_rdata;
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.mem_rvalid)
            rdata_reg <= we_reg ? 32'b0 : al_rdata;
          else if (cnt_reg == CNT_LAST)
            timeout_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from the state register so that reset forces
  // them low immediately; req_ready is additionally masked while rst is held.
  assign bus.req_ready    = (state_reg == S_IDLE) && !rst;
  assign bus.rsp_valid    = (state_reg == S_RESP) || (state_reg == S_ERR);
  assign bus.rsp_rdata    = (state_reg == S_RESP) ? rdata_reg : 32'b0;
  assign bus.rsp_misalign = (state_reg == S_ERR);
  assign bus.rsp_timeout  = (state_reg == S_RESP) && timeout_reg;
  assign bus.mem_req      = (state_reg == S_REQ);
  assign bus.mem_we       = (state_reg == S_REQ) && we_reg;
  assign bus.mem_be       = (state_reg == S_REQ) ? be_reg    : 4'b0;
  assign bus.mem_addr     = (state_reg == S_REQ) ? addr_reg  : '0;
  assign bus.mem_wdata    = (state_reg == S_REQ) ? wdata_reg : 32'b0;

endmodule
